// File: rtl/button_debounce.sv
// Per-bit button conditioner: two-flop synchroniser, saturating stability
// counter debounce, one-cycle press/release strobes and sticky press flags.
// All outputs are registered; nothing from an input reaches an output
// without passing through a flop.
module button_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
  output logic [WIDTH-1:0] buttons_stable,
  output logic [WIDTH-1:0] pressed_pulse,
  output logic [WIDTH-1:0] released_pulse,
  output logic [WIDTH-1:0] press_latched,
  input  logic [WIDTH-1:0] latch_clear
);

  // Terminal count: the stable level flips on the DEBOUNCE_CYCLES-th
  // consecutive cycle of disagreement.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] pressed_reg;
  logic [WIDTH-1:0] pressed_next;
  logic [WIDTH-1:0] released_reg;
  logic [WIDTH-1:0] released_next;
  logic [WIDTH-1:0] latched_reg;
  logic [WIDTH-1:0] latched_next;

  // Two-stage synchroniser; nothing sits between the stages so the first
  // flop has a full cycle to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= buttons_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // One independent stability counter per button bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             differ;
    logic             done;

    // Any agreement with the stable level restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES can never reach the terminal count.
    assign differ = sync2_reg[gi] ^ stable_reg[gi];
    assign done   = differ && (cnt_reg == CNT_MAX);

    assign cnt_next        = (!differ || done) ? '0 : cnt_reg + CNT_W'(1);
    assign stable_next[gi] = done ? sync2_reg[gi] : stable_reg[gi];

    // Counter state; saturates at CNT_MAX by clearing on the flip.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

  // Edge strobes derive from the next stable level so they line up with the
  // cycle in which buttons_stable first shows the new value.
  assign pressed_next  = stable_next & ~stable_reg;
  assign released_next = ~stable_next & stable_reg;

  // A press arriving with a clear on the same bit must not be lost.
  assign latched_next  = (latched_reg & ~latch_clear) | pressed_next;

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_reg   <= '0;
      pressed_reg  <= '0;
      released_reg <= '0;
      latched_reg  <= '0;
    end else begin
      stable_reg   <= stable_next;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
      latched_reg  <= latched_next;
    end
  end

  assign buttons_stable = stable_reg;
  assign pressed_pulse  = pressed_reg;
  assign released_pulse = released_reg;
  assign press_latched  = latched_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4.
// A behavioural model (raw delayed two edges, consecutive-disagreement run
// length per bit) predicts every output after every clock edge.
module tb_button_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] buttons_raw;
  logic [W-1:0] buttons_stable;
  logic [W-1:0] pressed_pulse;
  logic [W-1:0] released_pulse;
  logic [W-1:0] press_latched;
  logic [W-1:0] latch_clear;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [W-1:0] m_d1, m_d2, m_stable, m_pressed, m_released, m_latched;
  int           m_run [W];

  button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .buttons_stable(buttons_stable),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .press_latched (press_latched),
    .latch_clear   (latch_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_stable = '0;
    m_pressed = '0; m_released = '0; m_latched = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  task automatic check_all(input string where);
    check({where, ":stable"},   buttons_stable, m_stable);
    check({where, ":pressed"},  pressed_pulse,  m_pressed);
    check({where, ":released"}, released_pulse, m_released);
    check({where, ":latched"},  press_latched,  m_latched);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare #1 later.
  task automatic step(input logic [W-1:0] r, input logic [W-1:0] c);
    buttons_raw = r;
    latch_clear = c;
    @(posedge clk);
    m_pressed  = '0;
    m_released = '0;
    for (int b = 0; b < W; b++) begin
      if (m_d2[b] == m_stable[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_stable[b] = ~m_stable[b];
          m_run[b]    = 0;
          if (m_stable[b]) m_pressed[b] = 1'b1;
          else             m_released[b] = 1'b1;
        end
      end
    end
    m_latched = (m_latched & ~c) | m_pressed;
    m_d2 = m_d1;
    m_d1 = r;
    #1;
    check_all("step");
  endtask

  // Assert reset between edges, confirm outputs clear immediately, release
  // between edges one clock later.
  task automatic do_reset(input logic [W-1:0] r);
    buttons_raw = r;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst:stable",   buttons_stable, '0);
    check("async_rst:pressed",  pressed_pulse,  '0);
    check("async_rst:released", released_pulse, '0);
    check("async_rst:latched",  press_latched,  '0);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] raw;
    logic [W-1:0] clr;
    int           npulse;
    int           pulse_at;

    reset       = 1'b1;
    buttons_raw = 8'hFF;
    latch_clear = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    #2;
    reset = 1'b0;

    // 1. Bring everything pressed, then async reset with buttons held.
    for (int i = 0; i < 8; i++) step(8'hFF, 8'h00);
    check("t1:pre_reset_stable", buttons_stable, 8'hFF);
    do_reset(8'hFF);
    for (int i = 1; i <= 5; i++) step(8'hFF, 8'h00);
    check("t1:edge5_stable", buttons_stable, 8'h00);
    step(8'hFF, 8'h00);
    check("t1:edge6_stable",  buttons_stable, 8'hFF);
    check("t1:edge6_pressed", pressed_pulse,  8'hFF);
    check("t1:edge6_latched", press_latched,  8'hFF);
    step(8'hFF, 8'h00);
    check("t1:edge7_pressed", pressed_pulse, 8'h00);

    // Release everything, clear latches.
    for (int i = 0; i < 10; i++) step(8'h00, 8'hFF);
    check("t1:all_clear", press_latched, 8'h00);

    // 2. Clean press then release on bit 0.
    for (int i = 1; i <= 5; i++) step(8'h01, 8'h00);
    check("t2:press_edge5", buttons_stable, 8'h00);
    step(8'h01, 8'h00);
    check("t2:press_edge6", buttons_stable, 8'h01);
    check("t2:press_pulse", pressed_pulse,  8'h01);
    step(8'h01, 8'h00);
    check("t2:press_pulse_end", pressed_pulse, 8'h00);
    for (int i = 0; i < 4; i++) step(8'h01, 8'h00);
    for (int i = 1; i <= 5; i++) step(8'h00, 8'h00);
    check("t2:rel_edge5", buttons_stable, 8'h01);
    step(8'h00, 8'h00);
    check("t2:rel_edge6", buttons_stable, 8'h00);
    check("t2:rel_pulse", released_pulse, 8'h01);
    step(8'h00, 8'h00);
    check("t2:rel_pulse_end", released_pulse, 8'h00);

    // 3. Glitch of 3 cycles on bit 3 is rejected, then a real press.
    for (int i = 0; i < 3; i++) step(8'h08, 8'h00);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 8'h00);
      if (buttons_stable[3] || pressed_pulse[3] || released_pulse[3]) npulse++;
    end
    check("t3:glitch_rejected", npulse, 0);
    for (int i = 1; i <= 6; i++) step(8'h08, 8'h00);
    check("t3:press_edge6", buttons_stable, 8'h08);

    // 4. Bounce burst on bit 5, then settle high.
    raw = 8'h08;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(raw | (((i / 2) % 2 == 0) ? 8'h20 : 8'h00), 8'h00);
      if (pressed_pulse[5]) npulse++;
    end
    pulse_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(raw | 8'h20, 8'h00);
      if (pressed_pulse[5]) begin
        npulse++;
        pulse_at = i;
      end
    end
    check("t4:one_pulse", npulse, 1);
    check("t4:pulse_edge", pulse_at, DC + 2);

    // 5. Latch clear, and set winning over a simultaneous clear on bit 2.
    raw = 8'h28;
    step(raw, 8'hFF);
    for (int i = 0; i < 8; i++) step(raw | 8'h04, 8'h00);
    check("t5:latched_set", press_latched[2], 1'b1);
    step(raw | 8'h04, 8'h04);
    check("t5:latched_cleared", press_latched[2], 1'b0);
    for (int i = 0; i < 8; i++) step(raw, 8'h00);
    for (int i = 1; i <= 5; i++) step(raw | 8'h04, 8'h00);
    step(raw | 8'h04, 8'h04);
    check("t5:set_wins_pulse", pressed_pulse[2], 1'b1);
    check("t5:set_wins_latch", press_latched[2], 1'b1);

    // 6. Bits 1 and 6 pressed while bit 7 released on the same cycle.
    raw = 8'h2C;
    for (int i = 0; i < 8; i++) step(raw | 8'h80, 8'h00);
    for (int i = 1; i <= 6; i++) step(raw | 8'h42, 8'h00);
    check("t6:pressed",  pressed_pulse,  8'h42);
    check("t6:released", released_pulse, 8'h80);
    check("t6:stable",   buttons_stable, raw | 8'h42);

    // Randomised traffic with occasional clears and mid-debounce resets.
    raw = buttons_raw;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
      clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 149) == 0) do_reset(raw);
      step(raw, clr);
      checks++;
      if ((pressed_pulse & released_pulse) != '0) begin
        failures++;
        $display("FAIL both_pulses got=%0h required=0", pressed_pulse & released_pulse);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
